mem_port_arbiter: RTL and testbench

Two-requester, round-robin arbiter sharing one 32-bit memory port between instruction fetch (port A) and data access (port B). It drives the select of the 32-bit 2:1 address/write-data muxes in front of the unified memory. It sequences each access through a fixed-latency memory. It returns read data with a one-cycle acknowledge, so fetch and load/store stages can stall on a shared memory without extra glue.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rr_pick2.sv | 33 +++
 rtl/twoToOneMux_32.sv | 20 ++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the memory-port arbiter.
//   - state_t     : arbiter FSM states (IDLE, BUSY, RESP)
//   - PORT_A/B    : encoding used for mem_sel, last_grant and grant_port
//   - cnt_width() : width of the BUSY-cycle counter for a given latency
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Port A is instruction fetch, port B is data access.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // The counter has to hold values 0..lat, since it keeps incrementing in
    // the last BUSY cycle and never wraps.
    function automatic int cnt_width(input int lat);
        if (lat < 1) begin
            return 1;
        end
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
//   Two-way round-robin pick. A lone requester always wins; on a tie the
//   port that did not win last time is chosen.
//   Ports:
//     req_a       in  1  request from port A
//     req_b       in  1  request from port B
//     last_grant  in  1  port that won the previous arbitration
//     grant_valid out 1  at least one request present
//     grant_port  out 1  winning port (PORT_A / PORT_B)
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_port
);

    always_comb begin
        grant_valid = req_a | req_b;
        grant_port  = PORT_A;
        if (req_a && req_b) begin
            // Tie: hand the port to whoever was not served last.
            grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant_port = PORT_B;
        end else begin
            grant_port = PORT_A;
        end
    end

endmodule

// File: rtl/twoToOneMux_32.sv
// twoToOneMux_32
//   Plain 2:1 multiplexer used on the unified-memory address and
//   write-data paths.
//   Ports:
//     a   in  W   leg selected when sel = 0
//     b   in  W   leg selected when sel = 1
//     sel in  1   select
//     y   out W   selected leg
module twoToOneMux_32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (A) and data access
//   (B). Arbitrates in IDLE, runs a fixed MEM_LAT-cycle access in BUSY,
//   then pulses the granted port's ack for one cycle in RESP.
//
//   Handshake (both ports): the requester raises req with its address (and,
//   for B, we/wdata) stable and holds it until it sees the one-cycle ack.
//   An ack is only ever issued to the port whose access just finished. If
//   req is still high in the cycle after ack, it is a fresh request and is
//   arbitrated again like any other.
//
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     a_req/a_addr/a_ack     fetch port
//     b_req/b_we/b_addr/
//     b_wdata/b_ack          data port
//     rdata                  read data of the last completed access
//     mem_sel                mux select (0 = A, 1 = B)
//     mem_en/mem_we          memory enable / write enable
//     mem_addr/mem_wdata     muxed address / write data
//     mem_rdata              memory read data, valid in last BUSY cycle
//     busy                   high in BUSY and RESP
//     dbg_state              current FSM state
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [DATA_W-1:0] a_addr,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int CW = cnt_width(MEM_LAT);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic              sel_q;
    logic              last_grant_q;
    logic [DATA_W-1:0] rdata_q;
    logic              a_ack_q;
    logic              b_ack_q;

    logic              grant_valid;
    logic              grant_port;
    logic              last_busy;
    logic [DATA_W-1:0] a_wdata_tie;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_pick2 u_pick (
        .req_a       (a_req),
        .req_b       (b_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign last_busy = (state_q == BUSY) && (cnt_q == LAST_CNT);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_q        <= PORT_A;
            last_grant_q <= PORT_B;
            rdata_q      <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            // Acks are registered so they line up exactly with RESP.
            a_ack_q <= last_busy && (sel_q == PORT_A);
            b_ack_q <= last_busy && (sel_q == PORT_B);

            if (state_q == IDLE && grant_valid) begin
                sel_q        <= grant_port;
                last_grant_q <= grant_port;
                cnt_q        <= '0;
            end

            // Counter runs through the whole BUSY phase and ends at
            // MEM_LAT; it is cleared again on the next grant.
            if (state_q == BUSY) begin
                cnt_q <= cnt_q + CW'(1);
            end

            // Captured for writes too; the value is simply unused then.
            if (last_busy) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath muxes
    // ------------------------------------------------------------------
    // Fetch never writes, so its write-data leg is constant zero.
    assign a_wdata_tie = '0;

    twoToOneMux_32 #(
        .W (DATA_W)
    ) u_addr_mux (
        .a   (a_addr),
        .b   (b_addr),
        .sel (sel_q),
        .y   (mem_addr)
    );

    twoToOneMux_32 #(
        .W (DATA_W)
    ) u_wdata_mux (
        .a   (a_wdata_tie),
        .b   (b_wdata),
        .sel (sel_q),
        .y   (mem_wdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign rdata     = rdata_q;
    assign mem_sel   = sel_q;
    assign mem_en    = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && (sel_q == PORT_B) && b_we;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req, b_req, b_we;
  logic [31:0] a_addr, b_addr, b_wdata, mem_rdata;
  logic        a_ack, b_ack, mem_sel, mem_en, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;
  state_t      dbg_state;

  mem_port_arbiter #(.MEM_LAT(LAT), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // second build with the shortest latency
  logic        rst_1, a_req_1, a_ack_1, b_ack_1, mem_sel_1, mem_en_1, mem_we_1, busy_1;
  logic [31:0] rdata_1, mem_addr_1, mem_wdata_1;
  logic [31:0] a_addr_1 = 32'h0000_0100;
  logic [31:0] mem_rdata_1 = 32'h0BAD_F00D;
  logic        b_req_1 = 1'b0;
  logic        b_we_1 = 1'b0;
  logic [31:0] b_addr_1 = 32'h0;
  logic [31:0] b_wdata_1 = 32'h0;
  state_t      dbg_state_1;

  mem_port_arbiter #(.MEM_LAT(1), .DATA_W(32)) dut1 (
    .clk(clk), .rst(rst_1),
    .a_req(a_req_1), .a_addr(a_addr_1), .a_ack(a_ack_1),
    .b_req(b_req_1), .b_we(b_we_1), .b_addr(b_addr_1), .b_wdata(b_wdata_1), .b_ack(b_ack_1),
    .rdata(rdata_1), .mem_sel(mem_sel_1), .mem_en(mem_en_1), .mem_we(mem_we_1),
    .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1),
    .busy(busy_1), .dbg_state(dbg_state_1)
  );

  // ---------------- counters ----------------
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction-level view: an access granted at some edge occupies LAT
  // cycles of memory, then one acknowledge cycle; m_age counts cycles since
  // the grant.
  bit          m_active = 1'b0;
  int          m_age = 0;
  logic        m_owner = 1'b0;
  logic        m_sel = 1'b0;
  logic        m_last = 1'b1;
  logic [31:0] m_rdata = 32'h0;
  logic [0:0]  exp_q[$];
  logic [0:0]  ack_log[$];

  bit keep_a = 1'b0, keep_b = 1'b0;
  int cnt_a_ack, cnt_b_ack, cnt_en, cnt_we;

  task automatic model_edge();
    logic w;
    if (rst) begin
      m_active = 1'b0;
      m_sel = 1'b0;
      m_last = 1'b1;
      m_rdata = 32'h0;
      exp_q.delete();
    end else if (m_active) begin
      if (m_age == LAT - 1) m_rdata = mem_rdata;
      if (m_age == LAT) m_active = 1'b0;
      else m_age++;
    end else if (a_req || b_req) begin
      if (a_req && b_req) w = (m_last == 1'b1) ? 1'b0 : 1'b1;  // the port not served last
      else w = b_req;
      m_owner = w;
      m_last = w;
      m_sel = w;
      m_active = 1'b1;
      m_age = 0;
      exp_q.push_back(w);
    end
  endtask

  task automatic check_outputs();
    bit     in_busy, in_resp;
    state_t es;
    logic [0:0] e;
    in_busy = m_active && (m_age < LAT);
    in_resp = m_active && (m_age == LAT);
    es = !m_active ? IDLE : (in_busy ? BUSY : RESP);
    chk("state", 32'(dbg_state), 32'(es));
    chk("a_ack", a_ack, in_resp && (m_owner == 1'b0));
    chk("b_ack", b_ack, in_resp && (m_owner == 1'b1));
    chk("ack_excl", a_ack & b_ack, 1'b0);
    chk("mem_en", mem_en, in_busy);
    chk("mem_we", mem_we, in_busy && m_owner && b_we);
    chk("busy", busy, m_active);
    chk("mem_sel", mem_sel, m_sel);
    chk("rdata", rdata, m_rdata);
    chk("mem_addr", mem_addr, m_sel ? b_addr : a_addr);
    chk("mem_wdata", mem_wdata, m_sel ? b_wdata : 32'h0);
    if (a_ack || b_ack) begin
      if (exp_q.size() == 0) begin
        chk("ack_expected", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", b_ack, e);
      end
      ack_log.push_back(b_ack);
    end
    cnt_a_ack += a_ack;
    cnt_b_ack += b_ack;
    cnt_en += mem_en;
    cnt_we += mem_we;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (a_ack && !keep_a) a_req = 1'b0;
    if (b_ack && !keep_b) b_req = 1'b0;
  endtask

  task automatic clear_stats();
    cnt_a_ack = 0; cnt_b_ack = 0; cnt_en = 0; cnt_we = 0;
    ack_log.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rst_1 = 1'b1; a_req_1 = 1'b0;
    a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
    a_addr = 32'h0; b_addr = 32'h0; b_wdata = 32'h0; mem_rdata = 32'h0;

    // reset
    step(); step();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    clear_stats();

    // single fetch
    a_req = 1'b1; a_addr = 32'h0000_0040; mem_rdata = 32'h2402_0005;
    step(); step(); step();
    chk("t1_a_ack_cycle3", a_ack, 1'b1);
    chk("t1_rdata", rdata, 32'h2402_0005);
    chk("t1_en_cycles", cnt_en, 32'd2);
    chk("t1_sel", mem_sel, 1'b0);
    step();

    // data write
    clear_stats();
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h1000_0000; b_wdata = 32'hDEAD_BEEF;
    step();
    chk("t3_sel", mem_sel, 1'b1);
    chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t3_addr", mem_addr, 32'h1000_0000);
    step(); step(); step();
    chk("t3_we_cycles", cnt_we, 32'(LAT));
    chk("t3_b_acks", cnt_b_ack, 32'd1);
    chk("t3_a_acks", cnt_a_ack, 32'd0);
    b_we = 1'b0;

    // B raised during an A access
    clear_stats();
    a_req = 1'b1; a_addr = 32'h0000_0080;
    step();
    b_req = 1'b1; b_addr = 32'h2000_0010;
    step();
    chk("t4_sel_busy", mem_sel, 1'b0);
    step();
    chk("t4_a_ack", a_ack, 1'b1);
    chk("t4_sel_resp", mem_sel, 1'b0);
    step();
    chk("t4_b_not_yet", mem_en, 1'b0);
    step();
    chk("t4_b_granted", mem_sel, 1'b1);
    step(); step(); step();
    chk("t4_b_acks", cnt_b_ack, 32'd1);

    // ties from reset alternate A,B,A,B
    rst = 1'b1; step(); rst = 1'b0;
    clear_stats();
    keep_a = 1'b1; keep_b = 1'b1;
    a_req = 1'b1; b_req = 1'b1; a_addr = 32'h0000_0200; b_addr = 32'h3000_0000;
    for (int i = 0; i < 4 * (LAT + 2); i++) begin
      mem_rdata = $urandom;
      step();
    end
    chk("t2_ack_count", ack_log.size(), 32'd4);
    if (ack_log.size() == 4) begin
      chk("t2_order0", ack_log[0], 1'b0);
      chk("t2_order1", ack_log[1], 1'b1);
      chk("t2_order2", ack_log[2], 1'b0);
      chk("t2_order3", ack_log[3], 1'b1);
    end
    keep_a = 1'b0; keep_b = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    for (int i = 0; i < LAT + 2; i++) step();

    // reset in second BUSY cycle
    clear_stats();
    a_req = 1'b1; a_addr = 32'h0000_0300; mem_rdata = 32'h5555_AAAA;
    step(); step();
    rst = 1'b1;
    step();
    chk("t5_state", 32'(dbg_state), 32'(IDLE));
    chk("t5_mem_en", mem_en, 1'b0);
    chk("t5_no_ack", a_ack | b_ack, 1'b0);
    chk("t5_rdata", rdata, 32'h0);
    rst = 1'b0;
    b_req = 1'b1; b_addr = 32'h4000_0000;
    step();
    chk("t5_tie_to_a", mem_sel, 1'b0);
    chk("t5_tie_en", mem_en, 1'b1);
    for (int i = 0; i < 2 * (LAT + 2); i++) step();
    chk("t5_a_acks", cnt_a_ack, 32'd1);
    chk("t5_b_acks", cnt_b_ack, 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!a_req && $urandom_range(0, 3) == 0) begin
        a_req = 1'b1; a_addr = $urandom; keep_a = ($urandom_range(0, 3) == 0);
      end else if (a_req && $urandom_range(0, 39) == 0) begin
        a_req = 1'b0;
      end
      if (!b_req && $urandom_range(0, 3) == 0) begin
        b_req = 1'b1; b_we = $urandom_range(0, 1); b_addr = $urandom; b_wdata = $urandom;
        keep_b = ($urandom_range(0, 3) == 0);
      end else if (b_req && $urandom_range(0, 39) == 0) begin
        b_req = 1'b0;
      end
      rst = ($urandom_range(0, 149) == 0);
      mem_rdata = $urandom;
      step();
      if (a_ack) keep_a = ($urandom_range(0, 3) == 0);
      if (b_ack) keep_b = ($urandom_range(0, 3) == 0);
    end
    rst = 1'b0;

    // MEM_LAT=1 build: held fetch acks every 3 cycles
    @(negedge clk);
    rst_1 = 1'b0; a_req_1 = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("lat1_a_ack", a_ack_1, (j % 3) == 2);
      if ((j % 3) == 2) chk("lat1_rdata", rdata_1, 32'h0BAD_F00D);
      chk("lat1_b_ack", b_ack_1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
